// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline package: default widths,
// write-back NOP control and lane indices.
package mips_pipe_pkg;
  localparam int CTRL_W = 2;
  localparam int RD_W   = 5;
  localparam int DATA_W = 32;

  localparam logic [CTRL_W-1:0] WB_CTRL_NOP = '0;

  localparam int LANE_MEM = 0;
  localparam int LANE_ALU = 1;
endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM->WB boundary bundle: upstream beat, downstream
// beat, flush and stall counter.
interface mem_wb_stage_if #(
  parameter int CTRL_W = mips_pipe_pkg::CTRL_W,
  parameter int RD_W   = mips_pipe_pkg::RD_W,
  parameter int DATA_W = mips_pipe_pkg::DATA_W,
  parameter int LANES  = 2,
  parameter int CNT_W  = 16
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [CTRL_W-1:0]       in_ctrl;
  logic [RD_W-1:0]         in_rd;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [CTRL_W-1:0]       out_ctrl;
  logic [RD_W-1:0]         out_rd;
  logic [LANES*DATA_W-1:0] out_data;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output flush, in_valid, in_ctrl,
    output in_rd, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl,
    input  out_rd, out_data, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_ctrl,
    input  in_rd, in_data, out_ready,
    output in_ready, out_valid, out_ctrl,
    output out_rd, out_data, stall_cnt
  );
endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register with one-entry skid;
// in_ready is taken straight from the skid flag.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_pay,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_pay
);
  logic         s_valid;
  logic [W-1:0] s_pay;
  logic         accept;
  logic         drain;
  logic         m_free;

  assign in_ready = ~s_valid;
  assign accept   = in_valid & ~s_valid;
  assign drain    = out_valid & out_ready;
  assign m_free   = ~out_valid | drain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      s_valid   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      s_valid   <= 1'b0;
    end else if (m_free) begin
      out_valid <= s_valid | accept;
      s_valid   <= 1'b0;
    end else if (accept) begin
      s_valid   <= 1'b1;
    end
  end

  // payload only moves with a real beat, so
  // invalid entries keep their stale contents
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_pay <= '0;
      s_pay   <= '0;
    end else begin
      if (m_free && (s_valid || accept))
        out_pay <= s_valid ? s_pay : in_pay;
      if (!m_free && accept)
        s_pay <= in_pay;
    end
  end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB stage register: skid-buffered beat with
// flush, bubble-masked control and stall counter.
module mem_wb_stage #(
  parameter int CTRL_W = mips_pipe_pkg::CTRL_W,
  parameter int RD_W   = mips_pipe_pkg::RD_W,
  parameter int DATA_W = mips_pipe_pkg::DATA_W,
  parameter int LANES  = 2,
  parameter int CNT_W  = 16
) (
  input logic            clk,
  input logic            rst,
  mem_wb_stage_if.slave  bus
);
  import mips_pipe_pkg::*;

  localparam int DW = LANES * DATA_W;
  localparam int PW = CTRL_W + RD_W + DW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              m_valid;
  logic [PW-1:0]     m_pay;
  logic [CTRL_W-1:0] m_ctrl;
  logic [CNT_W-1:0]  cnt;

  pipe_skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clr       (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_pay    ({bus.in_ctrl,
                 bus.in_rd,
                 bus.in_data}),
    .out_valid (m_valid),
    .out_ready (bus.out_ready),
    .out_pay   (m_pay)
  );

  assign m_ctrl = m_pay[PW-1 -: CTRL_W];
  assign bus.out_rd   = m_pay[DW +: RD_W];
  assign bus.out_data = m_pay[DW-1:0];
  assign bus.out_valid = m_valid;

  // a bubble must never enable a register write
  assign bus.out_ctrl =
    m_valid ? m_ctrl : CTRL_W'(WB_CTRL_NOP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (m_valid && !bus.out_ready &&
             cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
  end

  assign bus.stall_cnt = cnt;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table,
// corner sequences and a queue-model random run.
module tb_mem_wb_stage;
  import mips_pipe_pkg::*;

  localparam int CW = 4;

  typedef struct {
    logic       iv;
    logic [1:0] ic;
    logic [4:0] ird;
    logic       ordy;
    logic       fl;
    logic       ev;
    logic [1:0] ectrl;
    logic [4:0] erd;
    logic       eir;
    int         ecnt;
  } vec_t;

  typedef struct {
    logic [1:0]  ctrl;
    logic [4:0]  rd;
    logic [63:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_wb_stage_if #(.CNT_W(CW)) bus();

  mem_wb_stage #(.CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pk(logic [4:0] rd);
    logic [63:0] d;
    d[LANE_MEM*32 +: 32] = 32'(rd) ^ 32'hA5A5_0000;
    d[LANE_ALU*32 +: 32] = 32'(rd) + 32'h100;
    return d;
  endfunction

  task automatic drive(logic iv, logic [1:0] ic,
                       logic [4:0] rd,
                       logic [63:0] d,
                       logic ordy, logic fl);
    bus.in_valid  = iv;
    bus.in_ctrl   = ic;
    bus.in_rd     = rd;
    bus.in_data   = d;
    bus.out_ready = ordy;
    bus.flush     = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t  vt[13];
  beat_t q[$];
  beat_t b;
  int    mcnt;

  initial begin
    vt[0]  = '{1,1,3,1,0, 1,1,3,1,0};
    vt[1]  = '{1,2,4,0,0, 1,1,3,0,1};
    vt[2]  = '{1,3,5,0,0, 1,1,3,0,2};
    vt[3]  = '{1,3,5,0,0, 1,1,3,0,3};
    vt[4]  = '{1,3,5,1,0, 1,2,4,1,3};
    vt[5]  = '{1,3,5,1,0, 1,3,5,1,3};
    vt[6]  = '{0,3,6,1,0, 0,0,0,1,3};
    vt[7]  = '{0,3,7,1,0, 0,0,0,1,3};
    vt[8]  = '{1,2,9,0,0, 1,2,9,1,3};
    vt[9]  = '{1,1,10,0,0, 1,2,9,0,4};
    vt[10] = '{1,3,11,0,1, 0,0,0,1,5};
    vt[11] = '{0,3,12,1,0, 0,0,0,1,5};
    vt[12] = '{1,1,13,1,0, 1,1,13,1,5};

    do_reset();
    chk("rst_valid", 64'(bus.out_valid), 0);
    chk("rst_ctrl", 64'(bus.out_ctrl), 0);
    chk("rst_rd", 64'(bus.out_rd), 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_cnt", 64'(bus.stall_cnt), 0);
    chk("rst_ready", 64'(bus.in_ready), 1);

    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 5'(i), pk(5'(i)), 1, 0);
      tick();
      chk("str_valid", 64'(bus.out_valid), 1);
      chk("str_rd", 64'(bus.out_rd), 64'(i));
      chk("str_data", bus.out_data, pk(5'(i)));
      chk("str_cnt", 64'(bus.stall_cnt), 0);
    end
    drive(0, 0, 0, 0, 1, 0);
    tick();
    chk("str_end", 64'(bus.out_valid), 0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].iv, vt[i].ic, vt[i].ird,
            pk(vt[i].ird), vt[i].ordy, vt[i].fl);
      tick();
      chk($sformatf("vec%0d_valid", i),
          64'(bus.out_valid), 64'(vt[i].ev));
      chk($sformatf("vec%0d_ctrl", i),
          64'(bus.out_ctrl), 64'(vt[i].ectrl));
      chk($sformatf("vec%0d_rdy", i),
          64'(bus.in_ready), 64'(vt[i].eir));
      chk($sformatf("vec%0d_cnt", i),
          64'(bus.stall_cnt), 64'(vt[i].ecnt));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_rd", i),
            64'(bus.out_rd), 64'(vt[i].erd));
        chk($sformatf("vec%0d_data", i),
            bus.out_data, pk(vt[i].erd));
      end
    end

    do_reset();
    drive(1, 1, 1, pk(1), 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (20) tick();
    chk("sat_cnt", 64'(bus.stall_cnt), 15);
    chk("sat_valid", 64'(bus.out_valid), 1);

    do_reset();
    drive(1, 1, 20, pk(20), 0, 0);
    tick();
    drive(1, 2, 21, pk(21), 0, 0);
    tick();
    chk("full_rdy", 64'(bus.in_ready), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 0);
    chk("arst_ctrl", 64'(bus.out_ctrl), 0);
    chk("arst_rdy", 64'(bus.in_ready), 1);
    chk("arst_cnt", 64'(bus.stall_cnt), 0);
    chk("arst_rd", 64'(bus.out_rd), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_reset();
    q.delete();
    mcnt = 0;
    for (int c = 0; c < 600; c++) begin
      logic       iv, ordy, fl;
      logic [1:0] ic;
      logic [4:0] rd;
      logic [63:0] d;
      iv   = 1'($urandom_range(0, 3) != 0);
      ordy = 1'($urandom_range(0, 2) != 0);
      fl   = 1'($urandom_range(0, 15) == 0);
      ic   = 2'($urandom);
      rd   = 5'($urandom);
      d    = {$urandom, $urandom};
      drive(iv, ic, rd, d, ordy, fl);
      if (q.size() > 0 && !ordy && mcnt < 15)
        mcnt++;
      if (fl) begin
        q.delete();
      end else begin
        logic acc;
        acc = iv && q.size() < 2;
        if (q.size() > 0 && ordy)
          void'(q.pop_front());
        if (acc) begin
          b.ctrl = ic;
          b.rd   = rd;
          b.data = d;
          q.push_back(b);
        end
      end
      tick();
      chk("rnd_valid", 64'(bus.out_valid),
          64'(q.size() > 0));
      chk("rnd_rdy", 64'(bus.in_ready),
          64'(q.size() < 2));
      chk("rnd_cnt", 64'(bus.stall_cnt),
          64'(mcnt));
      if (q.size() > 0) begin
        chk("rnd_ctrl", 64'(bus.out_ctrl),
            64'(q[0].ctrl));
        chk("rnd_rd", 64'(bus.out_rd),
            64'(q[0].rd));
        chk("rnd_data", bus.out_data, q[0].data);
      end else begin
        chk("rnd_bubble", 64'(bus.out_ctrl), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Parametrised MEM→WB pipeline boundary register with valid/ready flow control, a one-entry skid buffer, flush, and bubble masking. It sits between the data-memory stage and the register-file write-back stage. It replaces the free-running stage register with one that can absorb a write-back stall without dropping or duplicating instructions. It sustains one transfer per cycle, and `in_ready` comes straight from a register.

## Interface
- `CTRL_W`, 2: width of the write-back control field (RegWrite, MemToReg, …)
- `RD_W`, 5: destination register index width
- `DATA_W`, 32: width of one data lane
- `LANES`, 2: number of data lanes carried (lane 0 = memory read data, lane 1 = ALU/address result)
- `CNT_W`, 16: width of the stall-cycle counter
- `clk` input 1: single clock; all state updates on its rising edge
- `rst` input 1: asynchronous, active-low reset (asserted when 0)
- `flush` input 1: discard all held and incoming beats this cycle
- `in_valid` input 1: MEM stage presents a beat
- `in_ready` output 1: stage can accept a beat
- `in_ctrl` input CTRL_W: write-back control
- `in_rd` input RD_W: destination register
- `in_data` input LANES*DATA_W: packed lanes, lane k at bits [k*DATA_W +: DATA_W]
- `out_valid` output 1: WB beat available
- `out_ready` input 1: WB stage consumes the beat
- `out_ctrl` output CTRL_W: control field, forced to 0 whenever `out_valid`=0
- `out_rd` output RD_W: destination register
- `out_data` output LANES*DATA_W: lanes
- `stall_cnt` output CNT_W: saturating count of cycles with `out_valid`=1 and `out_ready`=0

## Operation
- Storage: main register (M: valid, ctrl, rd, data) drives the outputs. Skid register (S) has the same fields.
- `in_ready` = !S.valid. It is 1 whenever the skid is empty, including during reset.
- Accept = `in_valid` & `in_ready`. Drain = `out_valid` & `out_ready`.
- Occupancy states: EMPTY (M, S invalid), ONE (M valid, S invalid), FULL (both valid).
  - EMPTY: on accept, the beat loads into M → ONE.
  - ONE: accept with drain → the beat reloads M, stays ONE. Drain only → EMPTY. Accept without drain → the beat goes to S → FULL. Neither → hold.
  - FULL: on drain, S moves to M and S clears → ONE. No accept is possible because `in_ready`=0. Otherwise hold.
- Flush has priority over everything:
  - M.valid and S.valid are cleared → EMPTY.
  - A beat accepted in the same cycle is discarded.
  - A drain in the same cycle still completes, so WB sees it that cycle.
- Bubble masking: `out_ctrl` = M.valid ? M.ctrl : 0. An invalid stage can therefore never enable a register write.
- Data and rd fields of invalid entries keep their stale values (no clearing). Only the valid flags and ctrl are reset.
- `stall_cnt` increments by 1 per stall cycle, saturates at 2^CNT_W−1, and is cleared only by reset.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost except by flush.

## Timing
- Latency: a beat accepted at edge N appears on the outputs after edge N (visible in cycle N+1). Throughput is 1 beat/cycle while `out_ready`=1.
- `out_ready` low for one cycle while `in_valid`=1 fills S. `in_ready` drops in the next cycle.
- Reset values:
  - `out_valid`=0, `out_ctrl`=0, `out_rd`=0, `out_data`=0, `stall_cnt`=0.
  - S cleared, so `in_ready`=1.
- Reset applies immediately on `rst` falling, independent of `clk`. Release is synchronised externally.
- Reset mid-operation drops both entries, with no partial write-back.
- No combinational path from `out_ready` to `in_ready`, or from `in_*` to `out_*`.

## Structure
- Shared package `mips_pipe_pkg`:
  - default widths `CTRL_W`, `RD_W`, `DATA_W`
  - constant `WB_CTRL_NOP` (all zero)
  - lane index constants `LANE_MEM`=0, `LANE_ALU`=1
- Sub-module `pipe_skid_buf`: generic valid/ready skid register over an opaque payload width. `mem_wb_stage` packs {ctrl, rd, data} into it and adds flush, bubble masking and `stall_cnt`.

## Test plan
- Reset mid-stream: hold `rst`=0 with FULL occupancy → `out_valid`=0, `out_ctrl`=0, `in_ready`=1, `stall_cnt`=0 immediately, with no clock edge required.
- Streaming: 8 beats with rd=1..8 and `out_ready`=1 → 8 outputs in order, each 1 cycle after acceptance, `stall_cnt` stays 0.
- Backpressure:
  - Sequence: stream rd=3,4,5; drop `out_ready` for 3 cycles after beat 3 appears.
  - Required response: rd=4 is held in S; `in_ready`=0 while FULL; rd=5 is accepted only after the drain; `stall_cnt`=3; the output order is 3,4,5.
- Flush while FULL with a simultaneous `in_valid` (ctrl=2'b11) → the next cycle is EMPTY, `out_ctrl`=0, and the incoming beat never appears.
- Saturation: with `CNT_W`=4, hold `out_ready`=0 with `out_valid`=1 for 20 cycles → `stall_cnt`=15.
- Bubble masking: `in_valid`=0 with `in_ctrl`=2'b11 → `out_ctrl` stays 0.
